ctlr_port_array: RTL

//  Parametrised successor to the single-pair controller interface in the CPU memory map.

---
 rtl/ctlr_port_array.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ctlr_port_array.sv
// Controller port array for the $4016/$4017 pair: strobe latch, per-port shift pulses and
// serial read-back in plain two-port or Four Score multitap layout.
module ctlr_port_array #(
    parameter int NUM_PORTS     = 2,
    parameter int MULTITAP      = 0,
    parameter int BITS_PER_PORT = 8,
    parameter int PULSE_LEN     = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clock_en,
    input  logic [15:0]          addr,
    input  logic                 r_en,
    input  logic [7:0]           w_data,
    input  logic [NUM_PORTS-1:0] ctlr_data,
    output logic [NUM_PORTS-1:0] ctlr_pulse,
    output logic                 ctlr_latch,
    output logic [7:0]           button_data_rd,
    output logic                 read_hit
);
    localparam int              PW    = $clog2(PULSE_LEN + 1);
    localparam logic [4:0]      BPP   = 5'(BITS_PER_PORT);
    localparam logic [4:0]      LIMIT = (MULTITAP != 0) ? 5'd24 : 5'(BITS_PER_PORT);
    localparam logic [PW-1:0]   PLEN  = PW'(PULSE_LEN);

    logic                 latch_q, latch_d;
    logic [7:0]           rd_q, rd_d;
    logic                 hit_q, hit_d;
    logic [4:0]           cnt_q  [2];
    logic [4:0]           cnt_d  [2];
    logic [PW-1:0]        pcnt_q [NUM_PORTS];
    logic [PW-1:0]        pcnt_d [NUM_PORTS];

    logic                 reg_hit, rd_en, wr_strobe, strobe_set, slot;
    logic [4:0]           k;
    logic                 src_pad, use_pad, fixed_bit, pad_bit, rd_bit;
    logic [1:0]           src_port, sel_port;
    logic [NUM_PORTS-1:0] req;
    logic                 unused_wdata;

    assign reg_hit      = (addr[15:1] == 15'h200B);
    assign slot         = addr[0];
    assign rd_en        = clock_en & r_en & reg_hit;
    assign wr_strobe    = clock_en & ~r_en & reg_hit & ~addr[0];
    assign strobe_set   = wr_strobe & w_data[0];
    assign k            = cnt_q[slot];
    assign unused_wdata = ^w_data[7:1];

    // Multitap: counts 0..15 walk pad a then pad a+2 ({k[3], slot}); 16..23 are the signature.
    always_comb begin
        src_pad   = 1'b0;
        src_port  = {1'b0, slot};
        fixed_bit = 1'b1;
        if (MULTITAP == 0) begin
            src_pad = (k < BPP);
        end else if (k < 5'd16) begin
            src_pad  = ({2'b00, k[2:0]} < BPP);
            src_port = {k[3], slot};
        end else if (k < 5'd24) begin
            fixed_bit = slot ? (k == 5'd18) : (k == 5'd19);
        end
    end

    // While strobed the pad is transparent: report its current level, never shift it.
    assign use_pad  = latch_q | src_pad;
    assign sel_port = latch_q ? {1'b0, slot} : src_port;

    always_comb begin
        pad_bit = 1'b1;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (2'(p) == sel_port) pad_bit = ~ctlr_data[p];
        end
    end

    assign rd_bit = use_pad ? pad_bit : fixed_bit;

    always_comb begin
        latch_d = latch_q;
        rd_d    = rd_q;
        hit_d   = rd_en;
        cnt_d   = cnt_q;
        if (wr_strobe) latch_d = w_data[0];
        if (rd_en) begin
            rd_d = {7'b0, rd_bit};
            if (!latch_q && cnt_q[slot] != LIMIT) cnt_d[slot] = cnt_q[slot] + 5'd1;
        end
        if (latch_q || strobe_set) begin
            cnt_d[0] = 5'd0;
            cnt_d[1] = 5'd0;
        end
    end

    // A request while a pulse is running reloads the timer, so the line never glitches high.
    always_comb begin
        req = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            req[p]    = rd_en & ~latch_q & src_pad & (2'(p) == src_port);
            pcnt_d[p] = pcnt_q[p];
            if (strobe_set)                pcnt_d[p] = '0;
            else if (req[p])               pcnt_d[p] = PLEN;
            else if (pcnt_q[p] != '0)      pcnt_d[p] = pcnt_q[p] - 1'b1;
        end
    end

    always_comb begin
        ctlr_pulse = '1;
        for (int p = 0; p < NUM_PORTS; p++) begin
            ctlr_pulse[p] = (pcnt_q[p] == '0);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            latch_q  <= 1'b0;
            rd_q     <= 8'h00;
            hit_q    <= 1'b0;
            cnt_q[0] <= 5'd0;
            cnt_q[1] <= 5'd0;
            for (int p = 0; p < NUM_PORTS; p++) pcnt_q[p] <= '0;
        end else if (clock_en) begin
            latch_q  <= latch_d;
            rd_q     <= rd_d;
            hit_q    <= hit_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            for (int p = 0; p < NUM_PORTS; p++) pcnt_q[p] <= pcnt_d[p];
        end
    end

    assign ctlr_latch     = latch_q;
    assign button_data_rd = rd_q;
    assign read_hit       = hit_q;

endmodule
